// File: rtl/difftest_wb_collector_pkg.sv
// Shared types and helpers for the difftest integer-writeback collector.
// Entry fields are sized for the widest supported configuration; narrower instances zero-extend.
package difftest_pkg;

   localparam int unsigned DROP_CNT_W  = 16;
   localparam int unsigned WB_DEST_MAX = 32;
   localparam int unsigned WB_DATA_MAX = 64;
   localparam int unsigned WB_SEQ_MAX  = 32;

   typedef struct packed {
      logic [WB_DEST_MAX-1:0] dest;
      logic [WB_DATA_MAX-1:0] data;
      logic [WB_SEQ_MAX-1:0]  seq;
   } wb_entry_t;

   function automatic logic [3:0] popcount(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/difftest_wb_collector_if.sv
// Writeback-in / entry-out stream bundle for the difftest collector.
// slave: the collector; master: the core/sink environment driving it.
interface difftest_wb_collector_if #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned DEST_W = 32,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned SEQ_W  = 32
);

   logic [NUM_CH-1:0]        io_in_valid;
   logic [NUM_CH*DEST_W-1:0] io_in_dest;
   logic [NUM_CH*DATA_W-1:0] io_in_data;
   logic                     io_out_valid;
   logic                     io_out_ready;
   logic [DEST_W-1:0]        io_out_dest;
   logic [DATA_W-1:0]        io_out_data;
   logic [SEQ_W-1:0]         io_out_seq;

   modport slave (
      input  io_in_valid, io_in_dest, io_in_data, io_out_ready,
      output io_out_valid, io_out_dest, io_out_data, io_out_seq
   );

   modport master (
      output io_in_valid, io_in_dest, io_in_data, io_out_ready,
      input  io_out_valid, io_out_dest, io_out_data, io_out_seq
   );

endinterface

// File: rtl/difftest_wb_collector_mwfifo.sv
// NUM_CH-write / 1-read FIFO of writeback entries with an occupancy output.
// Slots 0..wr_cnt-1 are written in order starting at the write pointer.
module difftest_wb_mwfifo
   import difftest_pkg::*;
#(
   parameter  int unsigned NUM_CH = 2,
   parameter  int unsigned DEPTH  = 8,
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned LVL_W  = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [LVL_W-1:0] wr_cnt,
   input  wb_entry_t        wr_slot [NUM_CH],
   input  logic             rd_en,
   output wb_entry_t        head,
   output logic [LVL_W-1:0] level
);

   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [PTR_W-1:0] head_idx;

   always_comb begin
      mem_d = mem_q;
      for (int unsigned j = 0; j < NUM_CH; j++) begin
         if (LVL_W'(j) < wr_cnt) begin
            mem_d[wptr_q + PTR_W'(j)] = wr_slot[j];
         end
      end
      wptr_d  = wptr_q + PTR_W'(wr_cnt);
      rptr_d  = rptr_q + PTR_W'(rd_en);
      level_d = level_q + wr_cnt - LVL_W'(rd_en);
   end

   // When empty, point at the entry last dequeued so the head fields hold.
   always_comb begin
      head_idx = rptr_q;
      if (level_q == '0) begin
         head_idx = rptr_q - PTR_W'(1);
      end
   end

   assign head  = mem_q[head_idx];
   assign level = level_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/difftest_wb_collector.sv
// Multi-channel integer-writeback collector: filters, compacts and sequences
// per-cycle writebacks into a single in-order stream, flagging overflow drops.
module difftest_wb_collector
   import difftest_pkg::*;
#(
   parameter  int unsigned NUM_CH  = 2,
   parameter  int unsigned DEPTH   = 8,
   parameter  int unsigned DEST_W  = 32,
   parameter  int unsigned DATA_W  = 64,
   parameter  int unsigned SEQ_W   = 32,
   parameter  bit          DROP_X0 = 1'b1,
   localparam int unsigned LVL_W   = $clog2(DEPTH) + 1
) (
   input  logic                  io_clock,
   input  logic                  io_reset_n,
   input  logic [7:0]            io_coreid,
   difftest_wb_collector_if.slave wb,
   output logic [7:0]            io_out_coreid,
   output logic [LVL_W-1:0]      io_level,
   output logic                  io_overflow,
   output logic [DROP_CNT_W-1:0] io_drop_count
);

   localparam int unsigned FREE_W = LVL_W + 1;

   logic [NUM_CH-1:0]     elig;
   logic [3:0]            k;
   logic [LVL_W-1:0]      level;
   logic                  out_valid;
   logic                  deq;
   logic [FREE_W-1:0]     free;
   logic                  accept;
   wb_entry_t             slot [NUM_CH];
   wb_entry_t             head;
   logic [LVL_W-1:0]      wr_cnt;

   logic [SEQ_W-1:0]      seq_q, seq_d;
   logic                  ovf_q, ovf_d;
   logic [DROP_CNT_W-1:0] drop_q, drop_d;
   logic [DROP_CNT_W:0]   drop_sum;
   logic [7:0]            coreid_q, coreid_d;

   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         elig[i] = wb.io_in_valid[i]
                   && !(DROP_X0 && (wb.io_in_dest[i*DEST_W +: DEST_W] == '0));
      end
      k = popcount(8'(elig));
   end

   assign out_valid = (level != '0);
   assign deq       = out_valid & wb.io_out_ready;
   assign free      = FREE_W'(DEPTH) - FREE_W'(level) + FREE_W'(deq);
   assign accept    = (FREE_W'(k) <= free);
   assign wr_cnt    = accept ? LVL_W'(k) : '0;

   // Slot j takes the eligible channel with exactly j eligible channels below it.
   always_comb begin
      for (int unsigned j = 0; j < NUM_CH; j++) begin
         slot[j] = '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (elig[i] && (popcount(8'(elig & NUM_CH'((1 << i) - 1))) == 4'(j))) begin
               slot[j].dest = WB_DEST_MAX'(wb.io_in_dest[i*DEST_W +: DEST_W]);
               slot[j].data = WB_DATA_MAX'(wb.io_in_data[i*DATA_W +: DATA_W]);
            end
         end
         slot[j].seq = WB_SEQ_MAX'(seq_q + SEQ_W'(j));
      end
   end

   always_comb begin
      seq_d    = seq_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;
      coreid_d = io_coreid;
      drop_sum = {1'b0, drop_q} + (DROP_CNT_W + 1)'(k);
      if (accept) begin
         seq_d = seq_q + SEQ_W'(k);
      end else begin
         ovf_d  = 1'b1;
         drop_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      end
   end

   always_ff @(posedge io_clock or negedge io_reset_n) begin
      if (!io_reset_n) begin
         seq_q    <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
         coreid_q <= '0;
      end else begin
         seq_q    <= seq_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
         coreid_q <= coreid_d;
      end
   end

   difftest_wb_mwfifo #(
      .NUM_CH (NUM_CH),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (io_clock),
      .rst_n   (io_reset_n),
      .wr_cnt  (wr_cnt),
      .wr_slot (slot),
      .rd_en   (deq),
      .head    (head),
      .level   (level)
   );

   assign wb.io_out_valid = out_valid;
   assign wb.io_out_dest  = head.dest[DEST_W-1:0];
   assign wb.io_out_data  = head.data[DATA_W-1:0];
   assign wb.io_out_seq   = head.seq[SEQ_W-1:0];
   assign io_out_coreid   = coreid_q;
   assign io_level        = level;
   assign io_overflow     = ovf_q;
   assign io_drop_count   = drop_q;

endmodule
